// File: rtl/regfile_responder.sv
// Register-file responder: accepts handshaked read/write requests and returns
// read data through a one-entry response buffer, with write-activity tracking.
module regfile_responder #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  RegWrite,
  input  logic [ADDR_W-1:0]     WriteRegister,
  input  logic [WIDTH-1:0]      WriteData,
  input  logic [ADDR_W-1:0]     ReadRegister1,
  input  logic [ADDR_W-1:0]     ReadRegister2,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [WIDTH-1:0]      ReadData1,
  output logic [WIDTH-1:0]      ReadData2,
  output logic [CNT_W-1:0]      WriteCount,
  output logic [2**ADDR_W-1:0]  WrittenMask
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state;
  logic [WIDTH-1:0]    regs [NREG];
  logic                accept;
  logic                wr_en;
  logic [WIDTH-1:0]    rd1_next;
  logic [WIDTH-1:0]    rd2_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign RespValid = (state == FULL);
  // A full buffer being drained this cycle can be refilled in the same cycle.
  assign ReqReady  = (state == EMPTY) || RespReady;
  assign accept    = ReqValid && ReqReady;
  assign wr_en     = accept && RegWrite && (WriteRegister != '0);

  // Write-first: a read of the register being written sees the new data.
  always_comb begin
    rd1_next = regs[ReadRegister1];
    rd2_next = regs[ReadRegister2];
    if (wr_en && (ReadRegister1 == WriteRegister)) rd1_next = WriteData;
    if (wr_en && (ReadRegister2 == WriteRegister)) rd2_next = WriteData;
    if (ReadRegister1 == '0) rd1_next = '0;
    if (ReadRegister2 == '0) rd2_next = '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= EMPTY;
      ReadData1   <= '0;
      ReadData2   <= '0;
      WriteCount  <= '0;
      WrittenMask <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        EMPTY:   if (accept) state <= FULL;
        FULL:    if (!accept && RespReady) state <= EMPTY;
        default: state <= EMPTY;
      endcase
      if (accept) begin
        ReadData1 <= rd1_next;
        ReadData2 <= rd2_next;
      end
      if (wr_en) begin
        regs[WriteRegister]        <= WriteData;
        WrittenMask[WriteRegister] <= 1'b1;
        WriteCount                 <= sat_inc(WriteCount);
      end
    end
  end

endmodule

// File: tb/tb_regfile_responder.sv
// Directed and randomized bench for regfile_responder against a behavioural model.
module tb_regfile_responder;
  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int NREG   = 2**ADDR_W;
  localparam int CMAX   = 2**CNT_W - 1;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              ReqValid, ReqReady, RegWrite, RespValid, RespReady;
  logic [ADDR_W-1:0] WriteRegister, ReadRegister1, ReadRegister2;
  logic [WIDTH-1:0]  WriteData, ReadData1, ReadData2;
  logic [CNT_W-1:0]  WriteCount;
  logic [NREG-1:0]   WrittenMask;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] m_regs [NREG];
  bit               m_valid;
  logic [WIDTH-1:0] m_rd1, m_rd2;
  int               m_count;
  logic [NREG-1:0]  m_mask;

  regfile_responder #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RespValid(RespValid), .RespReady(RespReady),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteCount(WriteCount), .WrittenMask(WrittenMask)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    m_valid = 0;
    m_rd1   = '0;
    m_rd2   = '0;
    m_count = 0;
    m_mask  = '0;
  endtask

  task automatic check_outputs();
    chk("resp_valid",   {63'b0, RespValid}, {63'b0, m_valid});
    chk("read_data1",   ReadData1, m_rd1);
    chk("read_data2",   ReadData2, m_rd2);
    chk("write_count",  WriteCount, m_count);
    chk("written_mask", WrittenMask, m_mask);
  endtask

  // Called at a negedge; drives one cycle of inputs and checks the result.
  task automatic cycle(input bit v, input bit w, input int wa, input logic [WIDTH-1:0] wd,
                       input int a1, input int a2, input bit rr);
    bit acc, eff;
    ReqValid = v; RegWrite = w; WriteRegister = wa[ADDR_W-1:0]; WriteData = wd;
    ReadRegister1 = a1[ADDR_W-1:0]; ReadRegister2 = a2[ADDR_W-1:0]; RespReady = rr;
    #1;
    chk("req_ready", {63'b0, ReqReady}, {63'b0, (!m_valid || rr)});
    acc = v && (!m_valid || rr);
    @(posedge Clk);
    if (acc) begin
      eff   = w && (wa != 0);
      m_rd1 = (a1 == 0) ? '0 : ((eff && a1 == wa) ? wd : m_regs[a1]);
      m_rd2 = (a2 == 0) ? '0 : ((eff && a2 == wa) ? wd : m_regs[a2]);
      if (eff) begin
        m_regs[wa] = wd;
        m_mask[wa] = 1'b1;
        if (m_count < CMAX) m_count++;
      end
      m_valid = 1;
    end else if (rr) begin
      m_valid = 0;
    end
    @(negedge Clk);
    check_outputs();
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 0; RegWrite = 0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0; RespReady = 0;
    model_reset();
    repeat (2) @(negedge Clk);
    check_outputs();
    Reset = 1'b0;
    #1;
    chk("reset_req_ready", {63'b0, ReqReady}, 64'd1);
    @(negedge Clk);

    // Test 1: forwarded write/read of r2
    cycle(1, 1, 2, 42, 2, 2, 1);
    chk("t1_rd1", ReadData1, 64'd42);
    chk("t1_rd2", ReadData2, 64'd42);
    chk("t1_count", WriteCount, 64'd1);
    chk("t1_mask", WrittenMask, 64'h4);

    // Test 2: write then read-only request with stray WriteData
    cycle(1, 1, 2, 15, 0, 0, 1);
    cycle(1, 0, 2, 20, 2, 2, 1);
    chk("t2_rd1", ReadData1, 64'd15);
    chk("t2_count", WriteCount, 64'd2);

    // Test 3: write r2, read unrelated registers
    cycle(1, 1, 2, 120, 3, 14, 1);
    chk("t3_rd1a", ReadData1, 64'd0);
    cycle(1, 0, 0, 0, 2, 3, 1);
    chk("t3_rd1b", ReadData1, 64'd120);
    chk("t3_rd2b", ReadData2, 64'd0);

    // Test 4: write to r0 is ignored
    cycle(1, 1, 0, 32'hDEADBEEF, 0, 0, 1);
    chk("t4_rd1", ReadData1, 64'd0);
    chk("t4_count", WriteCount, 64'd3);
    chk("t4_mask0", {63'b0, WrittenMask[0]}, 64'd0);

    // Test 5: backpressure stall then release
    cycle(1, 1, 5, 77, 5, 5, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 1, 6, 99, 6, 5, 0);
      chk("t5_stall_rd1", ReadData1, 64'd77);
      chk("t5_stall_mask6", {63'b0, WrittenMask[6]}, 64'd0);
    end
    cycle(1, 1, 6, 99, 6, 5, 1);
    chk("t5_rel_rd1", ReadData1, 64'd99);
    chk("t5_rel_rd2", ReadData2, 64'd77);
    cycle(0, 0, 0, 0, 0, 0, 1);
    chk("t5_drained", {63'b0, RespValid}, 64'd0);

    // Write counter saturates instead of wrapping
    for (int i = 0; i < CMAX + 2; i++) cycle(1, 1, 1, i, 1, 0, 1);
    chk("sat_count", WriteCount, CMAX);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3) != 0);

    // Test 6: asynchronous reset while a response is pending
    cycle(1, 1, 2, 5, 2, 2, 0);
    chk("t6_pre_valid", {63'b0, RespValid}, 64'd1);
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(negedge Clk);
    Reset = 1'b0;
    cycle(1, 0, 0, 0, 2, 2, 1);
    chk("t6_rd1", ReadData1, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
